// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Captures the decode control bundle, operands, indices and immediate for the
// execute stage. Optional macro HAZARD_DETECT_EN enables load-use detection;
// without it only flush creates bubbles and pc_write/if_id_write stay 1
// outside reset.
module id_ex_pipe_reg #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_memto_reg,
  input  logic             id_reg_write,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic [1:0]       id_alu_op,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [3:0]       id_funct4,
  output logic             ex_branch,
  output logic             ex_mem_read,
  output logic             ex_memto_reg,
  output logic             ex_reg_write,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic [1:0]       ex_alu_op,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_funct4,
  output logic             ex_valid,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [CNT_W-1:0] bubble_count
);

  logic hz;
  logic bubble;

  // Load-use hazard: a valid load in EX whose destination feeds either source
  // of the decode instruction. Both sources are compared even if unused.
`ifdef HAZARD_DETECT_EN
  always_comb begin
    hz = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
         ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  end
`else
  always_comb begin
    hz = 1'b0;
  end
`endif

  // Stall requests and the bubble decision; flush and hz merge into one bubble.
  always_comb begin
    pc_write    = ~hz & ~reset;
    if_id_write = ~hz & ~reset;
    bubble      = flush | hz;
  end

  // Pipeline slot: cleared on reset or bubble, otherwise a verbatim capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bubble) begin
      ex_branch    <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_memto_reg <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_src   <= 1'b0;
      ex_alu_op    <= 2'b00;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= 5'd0;
      ex_rs2       <= 5'd0;
      ex_rd        <= 5'd0;
      ex_funct4    <= 4'd0;
      ex_valid     <= 1'b0;
    end else begin
      ex_branch    <= id_branch;
      ex_mem_read  <= id_mem_read;
      ex_memto_reg <= id_memto_reg;
      ex_reg_write <= id_reg_write;
      ex_mem_write <= id_mem_write;
      ex_alu_src   <= id_alu_src;
      ex_alu_op    <= id_alu_op;
      ex_pc        <= id_pc;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_funct4    <= id_funct4;
      ex_valid     <= 1'b1;
    end
  end

  // Saturating count of inserted bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (bubble && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: stimulus pushes expected results from a
// slot-level reference model, a monitor pops and compares them.
module tb_id_ex_pipe_reg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic            flush;
    logic            branch, mem_read, memto_reg, reg_write, mem_write, alu_src;
    logic [1:0]      alu_op;
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [3:0]      funct4;
  } stim_t;

  typedef struct packed {
    logic            valid;
    logic            branch, mem_read, memto_reg, reg_write, mem_write, alu_src;
    logic [1:0]      alu_op;
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [3:0]      funct4;
  } slot_t;

  typedef struct {
    logic  pw;
    slot_t ex;
    int    cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic id_branch = 0, id_mem_read = 0, id_memto_reg = 0, id_reg_write = 0;
  logic id_mem_write = 0, id_alu_src = 0;
  logic [1:0] id_alu_op = '0;
  logic [XLEN-1:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [3:0] id_funct4 = '0;
  logic ex_branch, ex_mem_read, ex_memto_reg, ex_reg_write, ex_mem_write, ex_alu_src;
  logic [1:0] ex_alu_op;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_funct4;
  logic ex_valid, pc_write, if_id_write;
  logic [CNT_W-1:0] bubble_count;

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .id_branch(id_branch), .id_mem_read(id_mem_read), .id_memto_reg(id_memto_reg),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct4(id_funct4),
    .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_memto_reg(ex_memto_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct4(ex_funct4), .ex_valid(ex_valid),
    .pc_write(pc_write), .if_id_write(if_id_write), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  slot_t dut_ex;
  assign dut_ex = {ex_valid, ex_branch, ex_mem_read, ex_memto_reg, ex_reg_write,
                   ex_mem_write, ex_alu_src, ex_alu_op, ex_pc, ex_rs1_data, ex_rs2_data,
                   ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct4};

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  // Reference model: contents of the EX slot and the number of bubbles so far.
  slot_t m_ex  = '0;
  int    m_cnt = 0;

  task automatic check(input string name, input logic [XLEN*4+63:0] act,
                       input logic [XLEN*4+63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic model_hz(input stim_t s);
`ifdef HAZARD_DETECT_EN
    // A load currently in EX writing a nonzero register that decode reads.
    return m_ex.valid && m_ex.mem_read && m_ex.rd != 0 && (m_ex.rd == s.rs1 || m_ex.rd == s.rs2);
`else
    return 1'b0;
`endif
  endfunction

  // Apply one decode slot for one cycle; called just after a falling edge.
  task automatic drive(input stim_t s);
    exp_t e;
    logic hz;
    flush = s.flush; id_branch = s.branch; id_mem_read = s.mem_read;
    id_memto_reg = s.memto_reg; id_reg_write = s.reg_write; id_mem_write = s.mem_write;
    id_alu_src = s.alu_src; id_alu_op = s.alu_op; id_pc = s.pc;
    id_rs1_data = s.rs1_data; id_rs2_data = s.rs2_data; id_imm = s.imm;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; id_funct4 = s.funct4;
    hz   = model_hz(s);
    e.pw = !hz;
    if (s.flush || hz) begin
      m_ex = '0;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
    end else begin
      m_ex = {1'b1, s.branch, s.mem_read, s.memto_reg, s.reg_write, s.mem_write, s.alu_src,
              s.alu_op, s.pc, s.rs1_data, s.rs2_data, s.imm, s.rs1, s.rs2, s.rd, s.funct4};
    end
    e.ex  = m_ex;
    e.cnt = m_cnt;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.flush    = ($urandom_range(0, 99) < 15);
    s.branch   = $urandom_range(0, 1);
    s.mem_read = $urandom_range(0, 1);
    s.memto_reg = $urandom_range(0, 1);
    s.reg_write = $urandom_range(0, 1);
    s.mem_write = $urandom_range(0, 1);
    s.alu_src  = $urandom_range(0, 1);
    s.alu_op   = 2'($urandom_range(0, 3));
    s.pc       = {$urandom, $urandom};
    s.rs1_data = {$urandom, $urandom};
    s.rs2_data = {$urandom, $urandom};
    s.imm      = {$urandom, $urandom};
    s.rs1      = 5'($urandom_range(0, 7));
    s.rs2      = 5'($urandom_range(0, 7));
    s.rd       = 5'($urandom_range(0, 7));
    s.funct4   = 4'($urandom_range(0, 15));
    return s;
  endfunction

  // Asynchronous reset in the middle of a cycle, checked directly.
  task automatic do_reset();
    int n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check("drain_before_reset", 256'(q.size()), 256'(0));
    reset = 1'b1;
    #1;
    check("reset_slot", 256'(dut_ex), 256'(0));
    check("reset_count", 256'(bubble_count), 256'(0));
    check("reset_pc_write", 256'(pc_write), 256'(0));
    m_ex  = '0;
    m_cnt = 0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("post_reset_pc_write", 256'(pc_write), 256'(1));
    check("post_reset_if_id_write", 256'(if_id_write), 256'(1));
    check("post_reset_valid", 256'(ex_valid), 256'(0));
  endtask

  // Monitor: stall outputs before the edge, registered slot after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q[0];
        check("pc_write", 256'(pc_write), 256'(e.pw));
        check("if_id_write", 256'(if_id_write), 256'(e.pw));
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("ex_slot", 256'(dut_ex), 256'(e.ex));
        check("bubble_count", 256'(bubble_count), 256'(e.cnt));
      end
    end
  end

  initial begin
    stim_t s;
    int    n;
    @(negedge clk);
    #1;
    check("init_slot", 256'(dut_ex), 256'(0));
    check("init_count", 256'(bubble_count), 256'(0));
    reset = 1'b0;
    #1;
    check("init_pc_write", 256'(pc_write), 256'(1));

    // R-type pass-through.
    s = '0; s.reg_write = 1; s.alu_op = 2'b10; s.rd = 5; s.rs1 = 1; s.rs2 = 2;
    s.rs1_data = 64'h10; s.funct4 = 4'b1000;
    drive(s);

    // Load-use: ld x6 then add reading x6 twice (stall repeats same instruction).
    s = '0; s.mem_read = 1; s.memto_reg = 1; s.reg_write = 1; s.alu_src = 1; s.rd = 6;
    s.rs1 = 2; s.imm = 64'h8; s.pc = 64'h100;
    drive(s);
    s = '0; s.reg_write = 1; s.alu_op = 2'b10; s.rs1 = 3; s.rs2 = 6; s.rd = 7;
    s.pc = 64'h104; s.rs2_data = 64'hdead;
    drive(s);
    drive(s);

    // x0 rule: load to x0 followed by a read of x0.
    s = '0; s.mem_read = 1; s.rd = 0; s.reg_write = 1;
    drive(s);
    s = '0; s.rs1 = 0; s.rs2 = 0; s.rd = 9; s.reg_write = 1;
    drive(s);

    // Flush coinciding with a load-use hazard.
    s = '0; s.mem_read = 1; s.rd = 4; s.reg_write = 1;
    drive(s);
    s = '0; s.flush = 1; s.rs1 = 4; s.rd = 8; s.reg_write = 1;
    drive(s);

    // Five flushes saturate a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      s = rand_stim(); s.flush = 1;
      drive(s);
    end

    // Reset mid-stream with a register-writing instruction in EX.
    s = rand_stim(); s.flush = 0; s.reg_write = 1; s.mem_read = 0;
    drive(s);
    do_reset();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(rand_stim());
      if (i % 97 == 96) begin
        s = rand_stim(); s.flush = 0; s.reg_write = 1; s.mem_read = 0;
        drive(s);
        do_reset();
      end
    end

    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check("final_drain", 256'(q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
